deserializador: RTL and testbench
=================================

DESERIALIZADOR -- requirements
Module: deserializador

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 BITS, default 8, parallel word width in bits.
REQ-003 clk  input  1  rising-edge clock, one serial bit per cycle.
REQ-004 reset_L  input  1  asynchronous active-low reset.
REQ-005 data  input  1  serial bit stream, MSB of each word first.
REQ-006 DK  input  1  word-type flag: 1 = control (K) word, 0 = data (D) word.
REQ-007 out_DK  output  1  registered type flag of the last completed word.
REQ-008 out  output  BITS  registered last completed parallel word.

Function
REQ-009 Shift register sr[BITS-1:0] SHALL update every rising edge out of reset: sr <= {sr[BITS-2:0], data}.
REQ-010 The FSM SHALL have exactly two states, SEARCH and LOCKED.
REQ-011 The alignment character COMMA SHALL be 8'hBC, valid only when DK=1.
REQ-012 In SEARCH, the FSM SHALL go to LOCKED on the edge where the shifted value equals COMMA and DK=1; on that edge out<=COMMA, out_DK<=1, bit counter cnt<=0.
REQ-013 In SEARCH, with no COMMA match, out and out_DK SHALL hold their values.
REQ-014 In LOCKED, cnt (0..BITS-1) SHALL increment every edge and wrap from BITS-1 to 0.
REQ-015 In LOCKED, on the edge with cnt==BITS-1, out SHALL take the shifted value (including the current data bit) and out_DK SHALL take DK sampled on that edge; latency = 0 cycles after the last bit edge.
REQ-016 In LOCKED, out and out_DK SHALL hold on all edges with cnt!=BITS-1; DK is ignored on those edges.
REQ-017 In LOCKED, a COMMA+DK=1 match with cnt!=BITS-1 SHALL realign: out<=COMMA, out_DK<=1, cnt<=0.
REQ-018 A COMMA match with cnt==BITS-1 SHALL be treated as a normal word: out=8'hBC, out_DK=1, no realignment.
REQ-019 LOCKED SHALL exit only through reset; there is no loss-of-lock detection.

Reset
REQ-020 With reset_L=0, out=0, out_DK=0, sr=0, cnt=0 and state=SEARCH, immediately and independent of clk.
REQ-021 Reset asserted mid-word SHALL discard the partial word.
REQ-022 After reset_L rises, operation SHALL resume from the first following rising clk edge.

Structure
REQ-023 Shared package serdes_pkg SHALL hold COMMA (8'hBC), the default BITS value and the SEARCH/LOCKED state encoding.
REQ-024 The serial-to-parallel shift register SHALL be one sub-module, deser_shift_reg; the FSM and counter SHALL stay in deserializador.
REQ-025 The stimulus generator (tester) SHALL be a separate module, not part of the DUT.

Verification
REQ-026 reset_L=0 mid-word in LOCKED -> out=8'h00, out_DK=0 at once; data 1,0,1,0,0,1,0,1 with DK=0 afterward -> out stays 8'h00.
REQ-027 From SEARCH, serial 1,0,1,1,1,1,0,0 with DK=1 on the 8th edge -> out=8'hBC, out_DK=1 on that edge; state LOCKED.
REQ-028 LOCKED, serial 8'hA5 (1,0,1,0,0,1,0,1) with DK=0 -> out=8'hA5, out_DK=0 on the 8th edge; out holds 8'hBC on edges 1-7.
REQ-029 LOCKED, serial 8'h7C with DK=1 on the final edge -> out=8'h7C, out_DK=1.
REQ-030 LOCKED, COMMA inserted 3 bits off the word boundary -> out=8'hBC at the match edge; the next 8 bits 8'h3C with DK=0 -> out=8'h3C, out_DK=0.
REQ-031 Serial 8'hBC with DK=0 in SEARCH -> no lock; out stays 8'h00.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared constants for the serial deserializer: comma character, default width, FSM states.
package serdes_pkg;
  localparam int         BITS_DEFAULT = 8;
  localparam logic [7:0] COMMA        = 8'hBC;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;
endpackage

// File: rtl/deser_shift_reg.sv
// Serial-to-parallel shifter, MSB first; shifted_o is the word including the bit on data_i this cycle.
module deser_shift_reg #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            data_i,
  output logic [BITS-1:0] shifted_o
);
  // The oldest bit falls off on the next shift and is never consumed, so only BITS-1 bits are stored.
  logic [BITS-2:0] sr_q;

  assign shifted_o = {sr_q, data_i};

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sr_q <= '0;
    end else begin
      sr_q <= shifted_o[BITS-2:0];
    end
  end
endmodule

// File: rtl/deserializador.sv
// Comma-aligned deserializer: locks on K-type 8'hBC, then emits one word every BITS bits.
module deserializador
  import serdes_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            data,
  input  logic            DK,
  output logic            out_DK,
  output logic [BITS-1:0] out
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [BITS-1:0] out_q;
  logic            out_dk_q;
  logic [BITS-1:0] shifted;
  logic            comma_hit;

  deser_shift_reg #(.BITS(BITS)) u_shift (
    .clk      (clk),
    .reset_L  (reset_L),
    .data_i   (data),
    .shifted_o(shifted)
  );

  assign comma_hit = DK && (shifted == BITS'(COMMA));
  assign out       = out_q;
  assign out_DK    = out_dk_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= SEARCH;
      cnt_q    <= '0;
      out_q    <= '0;
      out_dk_q <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (comma_hit) begin
            state_q  <= LOCKED;
            cnt_q    <= '0;
            out_q    <= BITS'(COMMA);
            out_dk_q <= 1'b1;
          end
        end
        LOCKED: begin
          // Word boundary wins over a comma match: a comma landing here is just a normal K word.
          if (cnt_q == LAST) begin
            cnt_q    <= '0;
            out_q    <= shifted;
            out_dk_q <= DK;
          end else if (comma_hit) begin
            cnt_q    <= '0;
            out_q    <= BITS'(COMMA);
            out_dk_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_deserializador.sv
// Randomized bench for deserializador against a bit-history reference model, plus directed word checks.
module tb_deserializador;
  import serdes_pkg::*;

  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            reset_L = 1'b0;
  logic            data = 1'b0;
  logic            DK = 1'b0;
  logic            out_DK;
  logic [BITS-1:0] out;

  int checks = 0;
  int failures = 0;

  // Reference model: last 8 bits seen, lock flag, bits received since the current word boundary.
  bit         m_locked = 1'b0;
  int         m_pos = 0;
  int         m_hist = 0;
  logic [7:0] m_out = 8'h00;
  logic       m_dk = 1'b0;

  always #5 clk = ~clk;

  deserializador #(.BITS(BITS)) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .data   (data),
    .DK     (DK),
    .out_DK (out_DK),
    .out    (out)
  );

  task automatic check(input string name, input logic [7:0] got, input logic gdk,
                       input logic [7:0] exp, input logic edk);
    checks++;
    if (got !== exp || gdk !== edk) begin
      failures++;
      $display("FAIL %s t=%0t: got out=%h out_DK=%b, expected out=%h out_DK=%b",
               name, $time, got, gdk, exp, edk);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_pos    = 0;
    m_hist   = 0;
    m_out    = 8'h00;
    m_dk     = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic k);
    m_hist = ((m_hist << 1) | int'(b)) & 'hFF;
    if (!m_locked) begin
      if (k && m_hist == int'(COMMA)) begin
        m_locked = 1'b1;
        m_pos    = 0;
        m_out    = COMMA;
        m_dk     = 1'b1;
      end
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == BITS) begin
        m_pos = 0;
        m_out = 8'(m_hist);
        m_dk  = k;
      end else if (k && m_hist == int'(COMMA)) begin
        m_pos = 0;
        m_out = COMMA;
        m_dk  = 1'b1;
      end
    end
  endtask

  // Every edge: DUT outputs must match the model.
  always @(posedge clk) begin
    #1;
    check("cycle", out, out_DK, m_out, m_dk);
  end

  task automatic step(input logic b, input logic k);
    @(negedge clk);
    data = b;
    DK   = k;
    model_step(b, k);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_L = 1'b1;
    data    = 1'b0;
    DK      = 1'b0;
    model_step(1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w, input logic dk_last);
    for (int i = 7; i >= 0; i--) step(w[i], (i == 0) ? dk_last : 1'b0);
  endtask

  task automatic lit_after_edge(input string name, input logic [7:0] exp, input logic edk);
    @(posedge clk);
    #2;
    check(name, out, out_DK, exp, edk);
  endtask

  initial begin
    logic [7:0] w;
    logic       rb;
    logic       rk;
    int         r;

    #1;
    check("reset_state", out, out_DK, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    release_reset();

    send_word(8'hBC, 1'b0);
    lit_after_edge("comma_dk0_no_lock", 8'h00, 1'b0);

    send_word(8'hBC, 1'b1);
    lit_after_edge("lock_on_comma", 8'hBC, 1'b1);

    w = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      step(w[i], 1'b0);
      if (i != 0) lit_after_edge("hold_mid_word", 8'hBC, 1'b1);
    end
    lit_after_edge("word_a5", 8'hA5, 1'b0);

    send_word(8'h7C, 1'b1);
    lit_after_edge("word_7c_k", 8'h7C, 1'b1);

    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    send_word(8'hBC, 1'b1);
    lit_after_edge("realign_comma", 8'hBC, 1'b1);
    send_word(8'h3C, 1'b0);
    lit_after_edge("word_3c_after_realign", 8'h3C, 1'b0);

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check("async_reset_mid_word", out, out_DK, 8'h00, 1'b0);
    release_reset();
    send_word(8'hA5, 1'b0);
    lit_after_edge("no_word_after_reset", 8'h00, 1'b0);

    w = COMMA;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        for (int i = 7; i >= 0; i--) step(w[i], (i == 0));
      end else if (r == 4) begin
        @(negedge clk);
        reset_L = 1'b0;
        model_reset();
        release_reset();
      end else begin
        rb = 1'($urandom_range(0, 1));
        rk = ($urandom_range(0, 3) == 0);
        step(rb, rk);
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
